// File: rtl/regfile_param.sv
// Parametrised register file: two registered read ports, one write port,
// optional hardwired-zero r0, optional write-to-read bypass, busy scoreboard.
module regfile_param #(
    parameter  int unsigned WIDTH    = 16,
    parameter  int unsigned ADDR_W   = 3,
    parameter  int unsigned ZERO_REG = 1,
    parameter  int unsigned BYPASS   = 1,
    localparam int unsigned DEPTH    = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [WIDTH-1:0]  out1,
    output logic [WIDTH-1:0]  out2,
    output logic              busy1,
    output logic              busy2,
    input  logic              RegWr,
    input  logic [ADDR_W-1:0] addr3,
    input  logic [WIDTH-1:0]  in,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic [DEPTH-1:0]  busy_vec
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;

    logic             w_wr_ok;
    logic             w_set_ok;
    logic [DEPTH-1:0] w_busy_next;
    logic [WIDTH-1:0] w_rd1_data;
    logic [WIDTH-1:0] w_rd2_data;
    logic             w_rd1_busy;
    logic             w_rd2_busy;

    // Qualify write and busy-set against the hardwired zero register
    always_comb begin
        w_wr_ok  = RegWr;
        w_set_ok = busy_set;
        if (ZERO_REG != 0) begin
            if (addr3 == ADDR_W'(0))     w_wr_ok  = 1'b0;
            if (busy_addr == ADDR_W'(0)) w_set_ok = 1'b0;
        end
    end

    // Next scoreboard: retiring write clears, new producer sets (set wins)
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_ok)  w_busy_next[addr3]     = 1'b0;
        if (w_set_ok) w_busy_next[busy_addr] = 1'b1;
    end

    // Read port 1 data/busy selection including bypass and zero register
    always_comb begin
        w_rd1_data = r_mem[addr1];
        w_rd1_busy = r_busy[addr1];
        if ((BYPASS != 0) && w_wr_ok && (addr3 == addr1)) begin
            w_rd1_data = in;
            w_rd1_busy = w_busy_next[addr1];
        end
        if ((ZERO_REG != 0) && (addr1 == ADDR_W'(0))) begin
            w_rd1_data = '0;
            w_rd1_busy = 1'b0;
        end
    end

    // Read port 2 data/busy selection including bypass and zero register
    always_comb begin
        w_rd2_data = r_mem[addr2];
        w_rd2_busy = r_busy[addr2];
        if ((BYPASS != 0) && w_wr_ok && (addr3 == addr2)) begin
            w_rd2_data = in;
            w_rd2_busy = w_busy_next[addr2];
        end
        if ((ZERO_REG != 0) && (addr2 == ADDR_W'(0))) begin
            w_rd2_data = '0;
            w_rd2_busy = 1'b0;
        end
    end

    // Storage and scoreboard update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_ok) r_mem[addr3] <= in;
            r_busy <= w_busy_next;
        end
    end

    // Registered read outputs, held while rd_en is low
    always_ff @(posedge clk) begin
        if (rst) begin
            out1  <= '0;
            out2  <= '0;
            busy1 <= 1'b0;
            busy2 <= 1'b0;
        end else if (rd_en) begin
            out1  <= w_rd1_data;
            out2  <= w_rd2_data;
            busy1 <= w_rd1_busy;
            busy2 <= w_rd2_busy;
        end
    end

    assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (zero-reg+bypass, plain) driven in
// parallel and checked against an array-based reference model.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [2:0]  addr1, addr2, addr3, busy_addr;
    logic [15:0] d_in;
    logic        reg_wr, busy_set;

    logic [15:0] o1 [2];
    logic [15:0] o2 [2];
    logic        b1 [2];
    logic        b2 [2];
    logic [7:0]  bv [2];

    // Reference model state, per instance
    logic [15:0] m_mem [2][8];
    logic [7:0]  m_busy [2];
    logic [15:0] m_o1 [2];
    logic [15:0] m_o2 [2];
    logic        m_b1 [2];
    logic        m_b2 [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_param #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_zb (
        .clk(clk), .rst(rst), .rd_en(rd_en), .addr1(addr1), .addr2(addr2),
        .out1(o1[0]), .out2(o2[0]), .busy1(b1[0]), .busy2(b2[0]),
        .RegWr(reg_wr), .addr3(addr3), .in(d_in), .busy_set(busy_set),
        .busy_addr(busy_addr), .busy_vec(bv[0])
    );

    regfile_param #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut_pl (
        .clk(clk), .rst(rst), .rd_en(rd_en), .addr1(addr1), .addr2(addr2),
        .out1(o1[1]), .out2(o2[1]), .busy1(b1[1]), .busy2(b2[1]),
        .RegWr(reg_wr), .addr3(addr3), .in(d_in), .busy_set(busy_set),
        .busy_addr(busy_addr), .busy_vec(bv[1])
    );

    // One clock edge applied to the model of instance k
    task automatic model_edge(input int k);
        bit          zr, bp, wr, st;
        logic [7:0]  nb;
        zr = (k == 0);
        bp = (k == 0);
        if (rst) begin
            for (int i = 0; i < 8; i++) m_mem[k][i] = 16'h0;
            m_busy[k] = 8'h0;
            m_o1[k] = 16'h0; m_o2[k] = 16'h0; m_b1[k] = 1'b0; m_b2[k] = 1'b0;
            return;
        end
        wr = reg_wr   && !(zr && addr3 == 3'd0);
        st = busy_set && !(zr && busy_addr == 3'd0);
        nb = m_busy[k];
        if (wr) nb[addr3] = 1'b0;
        if (st) nb[busy_addr] = 1'b1;
        if (rd_en) begin
            if (zr && addr1 == 3'd0) begin
                m_o1[k] = 16'h0; m_b1[k] = 1'b0;
            end else if (bp && wr && addr3 == addr1) begin
                m_o1[k] = d_in; m_b1[k] = nb[addr1];
            end else begin
                m_o1[k] = m_mem[k][addr1]; m_b1[k] = m_busy[k][addr1];
            end
            if (zr && addr2 == 3'd0) begin
                m_o2[k] = 16'h0; m_b2[k] = 1'b0;
            end else if (bp && wr && addr3 == addr2) begin
                m_o2[k] = d_in; m_b2[k] = nb[addr2];
            end else begin
                m_o2[k] = m_mem[k][addr2]; m_b2[k] = m_busy[k][addr2];
            end
        end
        if (wr) m_mem[k][addr3] = d_in;
        m_busy[k] = nb;
    endtask

    // Advance one edge; outputs are stable 1 time unit afterwards
    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; rd_en = 1'b0; reg_wr = 1'b0; busy_set = 1'b0;
        addr1 = 3'd0; addr2 = 3'd0; addr3 = 3'd0; busy_addr = 3'd0; d_in = 16'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; tick();
        rst = 1'b0; reg_wr = 1'b1; addr3 = 3'd1; d_in = 16'h000A; busy_set = 1'b1; busy_addr = 3'd2; tick();
        idle_inputs(); rst = 1'b1; reg_wr = 1'b1; addr3 = 3'd1; d_in = 16'h5555; tick();
        idle_inputs(); rd_en = 1'b1; addr1 = 3'd1; addr2 = 3'd2; tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (o1[k] !== 16'h0) begin errors++; $display("FAIL reset_out1[%0d]: got %h want 0000", k, o1[k]); end
            checks++; if (o2[k] !== 16'h0) begin errors++; $display("FAIL reset_out2[%0d]: got %h want 0000", k, o2[k]); end
            checks++; if (b1[k] !== 1'b0 || b2[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b%b want 00", k, b1[k], b2[k]); end
            checks++; if (bv[k] !== 8'h00) begin errors++; $display("FAIL reset_busy_vec[%0d]: got %h want 00", k, bv[k]); end
        end
    endtask

    task automatic test_write_read();
        idle_inputs(); reg_wr = 1'b1; addr3 = 3'd5; d_in = 16'h1234; tick();
        idle_inputs(); rd_en = 1'b1; addr1 = 3'd5; addr2 = 3'd5; tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (o1[k] !== 16'h1234) begin errors++; $display("FAIL wr_rd_out1[%0d]: got %h want 1234", k, o1[k]); end
            checks++; if (o2[k] !== 16'h1234) begin errors++; $display("FAIL wr_rd_out2[%0d]: got %h want 1234", k, o2[k]); end
        end
    endtask

    task automatic test_bypass();
        idle_inputs(); reg_wr = 1'b1; addr3 = 3'd3; d_in = 16'h1111; tick();
        idle_inputs(); reg_wr = 1'b1; addr3 = 3'd3; d_in = 16'hBEEF; rd_en = 1'b1; addr1 = 3'd3; addr2 = 3'd5; tick();
        checks++; if (o1[0] !== 16'hBEEF) begin errors++; $display("FAIL bypass_on: got %h want beef", o1[0]); end
        checks++; if (o1[1] !== 16'h1111) begin errors++; $display("FAIL bypass_off: got %h want 1111", o1[1]); end
        idle_inputs(); rd_en = 1'b1; addr1 = 3'd3; tick();
        checks++; if (o1[1] !== 16'hBEEF) begin errors++; $display("FAIL bypass_off_next: got %h want beef", o1[1]); end
    endtask

    task automatic test_zero_reg();
        idle_inputs(); reg_wr = 1'b1; addr3 = 3'd0; d_in = 16'hFFFF; busy_set = 1'b1; busy_addr = 3'd0; tick();
        idle_inputs(); rd_en = 1'b1; addr1 = 3'd0; addr2 = 3'd0; tick();
        checks++; if (o1[0] !== 16'h0 || b1[0] !== 1'b0) begin errors++; $display("FAIL zero_reg_read: got %h/%b want 0000/0", o1[0], b1[0]); end
        checks++; if (bv[0][0] !== 1'b0) begin errors++; $display("FAIL zero_reg_busy_vec: got %b want 0", bv[0][0]); end
        checks++; if (o1[1] !== 16'hFFFF || b1[1] !== 1'b1) begin errors++; $display("FAIL plain_r0_read: got %h/%b want ffff/1", o1[1], b1[1]); end
    endtask

    task automatic test_scoreboard();
        idle_inputs(); rst = 1'b1; tick();
        idle_inputs(); busy_set = 1'b1; busy_addr = 3'd4; tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (bv[k] !== 8'h10) begin errors++; $display("FAIL sb_set[%0d]: got %h want 10", k, bv[k]); end
        end
        idle_inputs(); rd_en = 1'b1; addr1 = 3'd4; tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (b1[k] !== 1'b1) begin errors++; $display("FAIL sb_read[%0d]: got %b want 1", k, b1[k]); end
        end
        idle_inputs(); reg_wr = 1'b1; addr3 = 3'd4; d_in = 16'h4444; tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (bv[k] !== 8'h00) begin errors++; $display("FAIL sb_clear[%0d]: got %h want 00", k, bv[k]); end
        end
        idle_inputs(); reg_wr = 1'b1; addr3 = 3'd4; d_in = 16'h4545; busy_set = 1'b1; busy_addr = 3'd4;
        rd_en = 1'b1; addr1 = 3'd4; addr2 = 3'd4; tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (bv[k] !== 8'h10) begin errors++; $display("FAIL sb_set_wins[%0d]: got %h want 10", k, bv[k]); end
        end
        checks++; if (b1[0] !== 1'b1 || o1[0] !== 16'h4545) begin errors++; $display("FAIL sb_bypass_busy: got %b/%h want 1/4545", b1[0], o1[0]); end
    endtask

    task automatic test_hold_reset();
        idle_inputs(); reg_wr = 1'b1; addr3 = 3'd2; d_in = 16'h2222; tick();
        idle_inputs(); rd_en = 1'b1; addr2 = 3'd2; tick();
        idle_inputs(); reg_wr = 1'b1; addr3 = 3'd2; d_in = 16'h3333; addr2 = 3'd2; tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (o2[k] !== 16'h2222) begin errors++; $display("FAIL hold_out2[%0d]: got %h want 2222", k, o2[k]); end
        end
        idle_inputs(); rst = 1'b1; reg_wr = 1'b1; addr3 = 3'd6; d_in = 16'h6666; busy_set = 1'b1; busy_addr = 3'd6; tick();
        idle_inputs(); rd_en = 1'b1; addr1 = 3'd6; addr2 = 3'd2; tick();
        for (int k = 0; k < 2; k++) begin
            checks++; if (o1[k] !== 16'h0 || o2[k] !== 16'h0 || bv[k] !== 8'h0)
                begin errors++; $display("FAIL rst_midop[%0d]: got %h %h %h want 0000 0000 00", k, o1[k], o2[k], bv[k]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 39) == 0);
            rd_en     = ($urandom_range(0, 3) != 0);
            reg_wr    = $urandom_range(0, 1) == 1;
            busy_set  = ($urandom_range(0, 2) == 0);
            addr1     = 3'($urandom_range(0, 7));
            addr2     = 3'($urandom_range(0, 7));
            addr3     = 3'($urandom_range(0, 7));
            busy_addr = ($urandom_range(0, 3) == 0) ? addr3 : 3'($urandom_range(0, 7));
            d_in      = 16'($urandom);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o1[k] !== m_o1[k] || o2[k] !== m_o2[k] || b1[k] !== m_b1[k] || b2[k] !== m_b2[k] || bv[k] !== m_busy[k]) begin
                    errors++;
                    $display("FAIL random[%0d] cycle %0d: got %h %h %b %b %h want %h %h %b %b %h", k, n,
                             o1[k], o2[k], b1[k], b2[k], bv[k], m_o1[k], m_o2[k], m_b1[k], m_b2[k], m_busy[k]);
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_hold_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
